// File: rtl/sum_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter with two-digit
// seven-segment output (ones on HEX0, tens on HEX1 with leading-zero blanking).
module sum_bcd_display #(
    parameter int WIDTH          = 5,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] SUM,
    output logic             BUSY,
    output logic             DONE,
    output logic [7:0]       BCD,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [6:0] BLANK    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0] LAST_ITR = 3'(WIDTH - 1);

    state_t           state_q;
    logic [3:0]       tens_q, ones_q;
    logic [WIDTH-1:0] bin_q;
    logic [2:0]       cnt_q;
    logic             busy_q, done_q;
    logic [7:0]       bcd_q;
    logic [6:0]       hex0_q, hex1_q;

    logic [3:0]       tens_adj, ones_adj;
    logic [WIDTH+7:0] sh_d;
    logic [3:0]       tens_d, ones_d;
    logic [WIDTH-1:0] bin_d;

    // Active-low pattern table, g..a; polarity applied afterwards
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return SEG_ACTIVE_LOW ? s : ~s;
    endfunction

    always_comb begin
        tens_adj = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
        ones_adj = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;
        sh_d     = {tens_adj, ones_adj, bin_q} << 1;
        tens_d   = sh_d[WIDTH+7:WIDTH+4];
        ones_d   = sh_d[WIDTH+3:WIDTH];
        bin_d    = sh_d[WIDTH-1:0];
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
            tens_q  <= '0;
            ones_q  <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= 8'h00;
            hex0_q  <= BLANK;
            hex1_q  <= BLANK;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        bin_q   <= SUM;
                        tens_q  <= '0;
                        ones_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    tens_q <= tens_d;
                    ones_q <= ones_d;
                    bin_q  <= bin_d;
                    cnt_q  <= cnt_q + 3'd1;
                    if (cnt_q == LAST_ITR) begin
                        bcd_q   <= {tens_d, ones_d};
                        hex0_q  <= seg7(ones_d);
                        hex1_q  <= (tens_d == 4'd0) ? BLANK : seg7(tens_d);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign BCD  = bcd_q;
    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Directed bench for sum_bcd_display: reset, single conversions,
// back-to-back START, mid-conversion reset and a full 0..31 sweep.
module tb_sum_bcd_display;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] sum;
    logic       busy;
    logic       done;
    logic [7:0] bcd;
    logic [6:0] hex0;
    logic [6:0] hex1;

    int total = 0;
    int bad   = 0;

    sum_bcd_display #(.WIDTH(5), .SEG_ACTIVE_LOW(1'b1)) dut (
        .CLOCK_50(clk),
        .RESET   (rst),
        .START   (start),
        .SUM     (sum),
        .BUSY    (busy),
        .DONE    (done),
        .BCD     (bcd),
        .HEX0    (hex0),
        .HEX1    (hex1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference segment table (active-low, g..a)
    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        sum = '0;
        tick();
        tick();
        total++;
        if ({busy, done, bcd, hex0, hex1} !== {1'b0, 1'b0, 8'h00, 7'h7F, 7'h7F}) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b bcd=%h hex0=%b hex1=%b, want 0 0 00 1111111 1111111",
                     busy, done, bcd, hex0, hex1);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single(input logic [4:0] v, input logic [7:0] eb,
                               input logic [6:0] eh1, input logic [6:0] eh0);
        sum = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        sum = ~v;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL busy_phase v=%0d cyc=%0d: busy=%b done=%b, want 1 0", v, k, busy, done);
            end
            if (k < 4) tick();
        end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse v=%0d: busy=%b done=%b, want 0 1", v, busy, done);
        end
        total++;
        if (bcd !== eb || hex1 !== eh1 || hex0 !== eh0) begin
            bad++;
            $display("FAIL result v=%0d: bcd=%h hex1=%b hex0=%b, want %h %b %b",
                     v, bcd, hex1, hex0, eb, eh1, eh0);
        end
        tick();
        total++;
        if (done !== 1'b0 || bcd !== eb) begin
            bad++;
            $display("FAIL hold v=%0d: done=%b bcd=%h, want 0 %h", v, done, bcd, eb);
        end
    endtask

    task automatic test_back_to_back();
        sum = 5'd13;
        start = 1'b1;
        tick();
        for (int e = 1; e <= 14; e++) begin
            if (e == 2) sum = 5'd22;
            if (e == 7) start = 1'b0;
            if (e == 8) start = 1'b1;
            if (e == 9) start = 1'b0;
            tick();
            total++;
            if (done !== (e == 5 || e == 11)) begin
                bad++;
                $display("FAIL b2b_done e=%0d: done=%b, want %b", e, done, (e == 5 || e == 11));
            end
            if (e == 5) begin
                total++;
                if (bcd !== 8'h13 || hex1 !== 7'b1111001 || hex0 !== 7'b0110000) begin
                    bad++;
                    $display("FAIL b2b_first: bcd=%h hex1=%b hex0=%b, want 13 1111001 0110000",
                             bcd, hex1, hex0);
                end
            end
            if (e == 11) begin
                total++;
                if (bcd !== 8'h22 || hex1 !== 7'b0100100 || hex0 !== 7'b0100100) begin
                    bad++;
                    $display("FAIL b2b_second: bcd=%h hex1=%b hex0=%b, want 22 0100100 0100100",
                             bcd, hex1, hex0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        sum = 5'd27;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, done, bcd, hex0, hex1} !== {1'b0, 1'b0, 8'h00, 7'h7F, 7'h7F}) begin
            bad++;
            $display("FAIL mid_reset: busy=%b done=%b bcd=%h hex0=%b hex1=%b, want 0 0 00 7f 7f",
                     busy, done, bcd, hex0, hex1);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_quiet cyc=%0d: busy=%b done=%b, want 0 0", k, busy, done);
            end
        end
        test_single(5'd27, 8'h27, 7'b0100100, 7'b1111000);
    endtask

    task automatic test_sweep();
        logic [7:0] eb;
        logic [6:0] eh1, eh0;
        for (int v = 0; v < 32; v++) begin
            sum = 5'(v);
            start = 1'b1;
            tick();
            repeat (4) tick();
            tick();
            eb  = {4'(v / 10), 4'(v % 10)};
            eh0 = ref_seg(v % 10);
            eh1 = (v < 10) ? 7'b1111111 : ref_seg(v / 10);
            total++;
            if (done !== 1'b1 || bcd !== eb || hex1 !== eh1 || hex0 !== eh0) begin
                bad++;
                $display("FAIL sweep v=%0d: done=%b bcd=%h hex1=%b hex0=%b, want 1 %h %b %b",
                         v, done, bcd, hex1, hex0, eb, eh1, eh0);
            end
        end
        start = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sum = '0;
        test_reset();
        test_single(5'd13, 8'h13, 7'b1111001, 7'b0110000);
        test_single(5'd31, 8'h31, 7'b0110000, 7'b1111001);
        test_single(5'd9,  8'h09, 7'b1111111, 7'b0010000);
        test_single(5'd0,  8'h00, 7'b1111111, 7'b1000000);
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum_bcd_display.md
# sum_bcd_display

Sequential binary-to-BCD converter and seven-segment driver for the 5-bit adder result (LEDR[4:0] of the 4-bit adder lab). On a START request it captures the binary sum, converts it to two BCD digits with a one-iteration-per-cycle double-dabble engine, then drives HEX0 (ones) and HEX1 (tens) on the board displays. It sits downstream of the adder and presents the adder's result in decimal.

## Interface
- WIDTH, 5, bit width of SUM; legal range 1..6 (max value 63, always two decimal digits)
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (DE-board HEX); 0 = inverted polarity

- CLOCK_50  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  conversion request, sampled only in IDLE
- SUM  in  WIDTH  binary value to convert (adder LEDR output)
- BUSY  out  1  conversion in progress
- DONE  out  1  one-cycle pulse: new result valid on BCD/HEX
- BCD  out  8  [7:4] tens digit, [3:0] ones digit
- HEX0  out  7  ones digit segments, bit0=a … bit6=g
- HEX1  out  7  tens digit segments, bit0=a … bit6=g

## Operation
- States: IDLE, SHIFT. Registers: shift register {tens[3:0], ones[3:0], bin[WIDTH-1:0]}, iteration counter (3 bits), BUSY, DONE, BCD, HEX0, HEX1.
- IDLE: START=1 → load bin=SUM, tens=ones=0, counter=0, go SHIFT. START=0 → stay.
- SHIFT, each cycle: any nibble ≥5 gets +3 (both nibbles checked in parallel, adjust before shift), then shift whole register left 1; counter+1.
- On the WIDTH-th shift: write adjusted-and-shifted digits to BCD, encode to HEX0/HEX1, pulse DONE, return to IDLE.
- START during SHIFT is ignored; SUM changes after capture do not affect the result.
- Segment encoding (SEG_ACTIVE_LOW=1, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. SEG_ACTIVE_LOW=0 inverts all bits.
- Leading-zero blanking: tens digit 0 → HEX1 blank (all segments off: 1111111 active-low). HEX0 always shows its digit, including 0.
- BCD, HEX0, HEX1 hold the last completed result until the next completion.

## Timing
- Reset values: state=IDLE, BUSY=0, DONE=0, BCD=8'h00, HEX0=HEX1=blank (7'h7F when active-low, 7'h00 otherwise).
- RESET has priority over all activity; asserted mid-conversion → next cycle IDLE, BUSY=0, no DONE, outputs at reset values; partial result discarded.
- Edge 0: START captured. BUSY=1 after edges 0..4 (5 cycles for WIDTH=5, generally WIDTH cycles).
- Edges 1..WIDTH: one iteration each. At edge WIDTH: results registered, BUSY=0, DONE=1 for exactly one cycle.
- During the DONE cycle the block is in IDLE: START=1 there is accepted at the next edge. Continuous START gives one conversion per WIDTH+1 cycles (6 for WIDTH=5).
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset: RESET=1 for 2 cycles → BUSY=0, DONE=0, BCD=8'h00, HEX0=HEX1=7'h7F.
- SUM=5'd13, one-cycle START → BUSY high 5 cycles, DONE pulse on cycle 6, BCD=8'h13, HEX1=1111001, HEX0=0110000.
- SUM=5'd31 → BCD=8'h31, HEX1=0110000, HEX0=1111001; SUM=5'd9 → BCD=8'h09, HEX1=1111111, HEX0=0010000; SUM=0 → BCD=8'h00, HEX0=1000000, HEX1 blank.
- START held high, SUM changed 13→22 on cycle 2 of conversion → first DONE gives 8'h13, second DONE exactly 6 cycles later gives 8'h22; extra START pulses during BUSY produce no extra DONE.
- RESET pulsed on cycle 3 of a conversion of SUM=27 → BUSY=0 next cycle, no DONE, BCD=8'h00, HEX blank; a fresh START then yields 8'h27.
- Sweep SUM=0..31 back-to-back → every BCD matches decimal value, HEX outputs match encoding table.
